// File: rtl/irq_ctrl_param.sv
// Parametrised interrupt controller: synchronises N_SRC request lines, tracks level/edge
// pending state, arbitrates (fixed or rotating) and hands one vector to the CPU via ack/EOI.
module irq_ctrl_param #(
    parameter int N_SRC       = 8,
    parameter int VEC_W       = 3,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ROTATE      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic              reg_we,
    input  logic [1:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    output logic              cpu_int,
    output logic [VEC_W-1:0]  int_vec,
    input  logic              int_ack,
    input  logic              eoi
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [N_SRC-1:0]   sync_reg [SYNC_STAGES];
    logic [N_SRC-1:0]   s_prev_reg;
    logic [N_SRC-1:0]   enable_reg;
    logic [N_SRC-1:0]   mode_reg;
    logic [N_SRC-1:0]   pending_reg;
    logic [N_SRC-1:0]   pending_next;
    logic [VEC_W-1:0]   ptr_reg;

    logic [N_SRC-1:0]   sync_s;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   sw_clr;
    logic [N_SRC-1:0]   ack_clr;
    logic [N_SRC-1:0]   req_vec;
    logic [N_SRC-1:0]   rot_vec;
    logic [N_SRC-1:0]   scan_vec;
    logic               found;
    logic [VEC_W-1:0]   winner;
    int                 sum;
    logic               unused_wdata;

    assign unused_wdata = ^reg_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_reg[k] <= '0;
            s_prev_reg <= '0;
        end else begin
            sync_reg[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
            s_prev_reg <= sync_s;
        end
    end

    assign sync_s  = sync_reg[SYNC_STAGES-1];
    assign rise    = sync_s & ~s_prev_reg;
    assign sw_clr  = (reg_we && reg_addr == 2'd2) ? reg_wdata[N_SRC-1:0] : '0;
    assign req_vec = pending_reg & enable_reg;

    // A fresh rising edge always beats a clear in the same cycle, so no edge is lost.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pending
            assign ack_clr[gi] = (state_reg == REQ) && int_ack && (int_vec == VEC_W'(gi));
            assign pending_next[gi] = mode_reg[gi]
                ? ((pending_reg[gi] & ~(sw_clr[gi] | ack_clr[gi])) | rise[gi])
                : sync_s[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_reg  <= '0;
            mode_reg    <= '0;
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            if (reg_we && reg_addr == 2'd0) enable_reg <= reg_wdata[N_SRC-1:0];
            if (reg_we && reg_addr == 2'd1) mode_reg   <= reg_wdata[N_SRC-1:0];
        end
    end

    // Rotate the request vector so the search always starts at bit 0; ptr stays 0 in fixed mode.
    assign rot_vec = N_SRC'({req_vec, req_vec} >> ptr_reg);

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        sum      = 0;
        scan_vec = rot_vec;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && scan_vec[0]) begin
                found = 1'b1;
                sum   = int'(ptr_reg) + i;
                if (sum >= N_SRC) sum = sum - N_SRC;
                winner = VEC_W'(sum);
            end
            scan_vec = scan_vec >> 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cpu_int   <= 1'b0;
            int_vec   <= '0;
            ptr_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        state_reg <= REQ;
                        int_vec   <= winner;
                        cpu_int   <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state_reg <= SERVICE;
                        cpu_int   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state_reg <= IDLE;
                        if (ROTATE != 0)
                            ptr_reg <= (int_vec == VEC_W'(N_SRC-1)) ? '0 : int_vec + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            2'd0: reg_rdata = DATA_W'(enable_reg);
            2'd1: reg_rdata = DATA_W'(mode_reg);
            2'd2: reg_rdata = DATA_W'(pending_reg);
            default: reg_rdata = DATA_W'({int_vec, state_reg == SERVICE, state_reg == REQ});
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl_param.sv
// Bench for irq_ctrl_param: a fixed-priority and a rotating-priority instance share stimulus;
// expected grants come from a circular-scan model of the priority rules.
`timescale 1ns/1ps
module tb_irq_ctrl_param;
    localparam int N_SRC       = 8;
    localparam int VEC_W       = 3;
    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N_SRC-1:0]  irq_in = '0;
    logic              reg_we = 1'b0;
    logic [1:0]        reg_addr = '0;
    logic [DATA_W-1:0] reg_wdata = '0;
    logic              int_ack = 1'b0;
    logic              eoi = 1'b0;
    logic [DATA_W-1:0] rdata_f, rdata_r;
    logic              cpu_int_f, cpu_int_r;
    logic [VEC_W-1:0]  int_vec_f, int_vec_r;

    int pass_cnt  = 0;
    int total_cnt = 0;

    irq_ctrl_param #(.N_SRC(N_SRC), .VEC_W(VEC_W), .DATA_W(DATA_W),
                     .SYNC_STAGES(SYNC_STAGES), .ROTATE(0)) dut_fixed (
        .clk(clk), .reset(reset), .irq_in(irq_in), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(rdata_f), .cpu_int(cpu_int_f), .int_vec(int_vec_f),
        .int_ack(int_ack), .eoi(eoi));

    irq_ctrl_param #(.N_SRC(N_SRC), .VEC_W(VEC_W), .DATA_W(DATA_W),
                     .SYNC_STAGES(SYNC_STAGES), .ROTATE(1)) dut_rot (
        .clk(clk), .reset(reset), .irq_in(irq_in), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(rdata_r), .cpu_int(cpu_int_r), .int_vec(int_vec_r),
        .int_ack(int_ack), .eoi(eoi));

    always #10 clk = ~clk;

    // First requesting source found scanning circularly from 'start'; -1 when none.
    function automatic int model_winner(input logic [N_SRC-1:0] reqv, input int start);
        for (int k = 0; k < N_SRC; k++)
            if (reqv[(start + k) % N_SRC]) return (start + k) % N_SRC;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; irq_in = '0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        int_ack = 1'b0; eoi = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [DATA_W-1:0] df,
                            output logic [DATA_W-1:0] dr);
        reg_addr = a;
        #1;
        df = rdata_f;
        dr = rdata_r;
    endtask

    task automatic wait_int_f(input int budget);
        for (int i = 0; i < budget && cpu_int_f !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic wait_int_r(input int budget);
        for (int i = 0; i < budget && cpu_int_r !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; @(negedge clk); int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; @(negedge clk); eoi = 1'b0;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] df, dr;
        do_reset();
        total_cnt++; if (cpu_int_f !== 1'b0) $display("FAIL reset_cpu_int got %b want 0", cpu_int_f); else pass_cnt++;
        total_cnt++; if (int_vec_f !== '0) $display("FAIL reset_int_vec got %0d want 0", int_vec_f); else pass_cnt++;
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), df, dr);
            total_cnt++;
            if (df !== '0) $display("FAIL reset_reg%0d got %h want 0000", a, df); else pass_cnt++;
        end
        $display("reset: registers and outputs sampled");
    endtask

    task automatic test_single_edge();
        logic [DATA_W-1:0] df, dr;
        do_reset();
        reg_write(2'd0, 16'h0001);
        reg_write(2'd1, 16'h0001);
        irq_in = 8'h01;
        for (int k = 0; k <= SYNC_STAGES; k++) begin
            @(negedge clk);
            if (k == 0) irq_in = '0;
        end
        reg_read(2'd2, df, dr);
        total_cnt++; if (df !== 16'h0001) $display("FAIL edge_pending_lat got %h want 0001", df); else pass_cnt++;
        total_cnt++; if (cpu_int_f !== 1'b0) $display("FAIL edge_int_early got %b want 0", cpu_int_f); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (cpu_int_f !== 1'b1) $display("FAIL edge_int_lat got %b want 1", cpu_int_f); else pass_cnt++;
        total_cnt++; if (int_vec_f !== 3'd0) $display("FAIL edge_vec got %0d want 0", int_vec_f); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (cpu_int_f !== 1'b0) $display("FAIL edge_int_after_ack got %b want 0", cpu_int_f); else pass_cnt++;
        reg_read(2'd2, df, dr);
        total_cnt++; if (df !== 16'h0000) $display("FAIL edge_pending_ack got %h want 0000", df); else pass_cnt++;
        reg_read(2'd3, df, dr);
        total_cnt++; if (df[1] !== 1'b1) $display("FAIL edge_status_service got %h want bit1=1", df); else pass_cnt++;
        pulse_eoi();
        reg_read(2'd3, df, dr);
        total_cnt++; if (df !== 16'h0000) $display("FAIL edge_status_eoi got %h want 0000", df); else pass_cnt++;
        $display("single_edge: grant vec=%0d", int_vec_f);
    endtask

    task automatic test_fixed_priority();
        do_reset();
        reg_write(2'd0, 16'h0024);
        irq_in = 8'h24;
        wait_int_f(20);
        total_cnt++; if (cpu_int_f !== 1'b1) $display("FAIL fixed_int1 got %b want 1", cpu_int_f); else pass_cnt++;
        total_cnt++; if (int_vec_f !== 3'd2) $display("FAIL fixed_vec1 got %0d want 2", int_vec_f); else pass_cnt++;
        $display("fixed: first grant vec=%0d", int_vec_f);
        pulse_ack();
        irq_in = 8'h20;
        repeat (4) @(negedge clk);
        pulse_eoi();
        wait_int_f(20);
        total_cnt++; if (cpu_int_f !== 1'b1) $display("FAIL fixed_int2 got %b want 1", cpu_int_f); else pass_cnt++;
        total_cnt++; if (int_vec_f !== 3'd5) $display("FAIL fixed_vec2 got %0d want 5", int_vec_f); else pass_cnt++;
        $display("fixed: second grant vec=%0d", int_vec_f);
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_rotating();
        logic [VEC_W-1:0] exp_vec;
        logic [VEC_W-1:0] exp_list [4];
        int ptr;
        exp_list = '{3'd0, 3'd3, 3'd7, 3'd0};
        do_reset();
        reg_write(2'd0, 16'h0089);
        irq_in = 8'h89;
        ptr = 0;
        for (int r = 0; r < 4; r++) begin
            wait_int_r(20);
            exp_vec = VEC_W'(model_winner(8'h89, ptr));
            total_cnt++; if (cpu_int_r !== 1'b1) $display("FAIL rot_int_r%0d got %b want 1", r, cpu_int_r); else pass_cnt++;
            total_cnt++; if (int_vec_r !== exp_vec) $display("FAIL rot_model_r%0d got %0d want %0d", r, int_vec_r, exp_vec); else pass_cnt++;
            total_cnt++; if (int_vec_r !== exp_list[r]) $display("FAIL rot_seq_r%0d got %0d want %0d", r, int_vec_r, exp_list[r]); else pass_cnt++;
            $display("rotate: round %0d grant vec=%0d", r, int_vec_r);
            pulse_ack();
            pulse_eoi();
            ptr = (int'(exp_vec) + 1) % N_SRC;
        end
        irq_in = '0;
    endtask

    task automatic test_mask_swclear();
        logic [DATA_W-1:0] df, dr;
        do_reset();
        reg_write(2'd1, 16'h0010);
        irq_in = 8'h10; @(negedge clk); irq_in = '0;
        repeat (4) @(negedge clk);
        reg_read(2'd2, df, dr);
        total_cnt++; if (df !== 16'h0010) $display("FAIL mask_pending got %h want 0010", df); else pass_cnt++;
        total_cnt++; if (cpu_int_f !== 1'b0) $display("FAIL mask_int got %b want 0", cpu_int_f); else pass_cnt++;
        reg_write(2'd2, 16'h0010);
        reg_read(2'd2, df, dr);
        total_cnt++; if (df !== 16'h0000) $display("FAIL swclear_pending got %h want 0000", df); else pass_cnt++;
        irq_in = 8'h10; @(negedge clk); irq_in = '0;
        repeat (4) @(negedge clk);
        reg_write(2'd0, 16'h0010);
        wait_int_f(10);
        total_cnt++; if (cpu_int_f !== 1'b1) $display("FAIL unmask_int got %b want 1", cpu_int_f); else pass_cnt++;
        total_cnt++; if (int_vec_f !== 3'd4) $display("FAIL unmask_vec got %0d want 4", int_vec_f); else pass_cnt++;
        $display("mask: grant after unmask vec=%0d", int_vec_f);
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_handshake();
        logic [DATA_W-1:0] df, dr;
        do_reset();
        reg_write(2'd0, 16'h0001);
        reg_write(2'd1, 16'h0001);
        pulse_ack();
        reg_read(2'd3, df, dr);
        total_cnt++; if (df !== 16'h0000) $display("FAIL ack_idle_status got %h want 0000", df); else pass_cnt++;
        irq_in = 8'h01; @(negedge clk); irq_in = '0;
        wait_int_f(10);
        total_cnt++; if (cpu_int_f !== 1'b1) $display("FAIL hs_int got %b want 1", cpu_int_f); else pass_cnt++;
        pulse_eoi();
        reg_read(2'd3, df, dr);
        total_cnt++; if (df !== 16'h0001) $display("FAIL eoi_req_status got %h want 0001", df); else pass_cnt++;
        total_cnt++; if (cpu_int_f !== 1'b1) $display("FAIL eoi_req_int got %b want 1", cpu_int_f); else pass_cnt++;
        // New edge reaches the pending logic on the same clock as the ack.
        irq_in = 8'h01;
        for (int k = 0; k < SYNC_STAGES; k++) begin
            @(negedge clk);
            if (k == 0) irq_in = '0;
        end
        pulse_ack();
        reg_read(2'd2, df, dr);
        total_cnt++; if (df !== 16'h0001) $display("FAIL ack_edge_pending got %h want 0001", df); else pass_cnt++;
        reg_read(2'd3, df, dr);
        total_cnt++; if (df !== 16'h0002) $display("FAIL ack_edge_status got %h want 0002", df); else pass_cnt++;
        pulse_eoi();
        total_cnt++; if (cpu_int_f !== 1'b0) $display("FAIL eoi_gap_int got %b want 0", cpu_int_f); else pass_cnt++;
        wait_int_f(10);
        total_cnt++; if (cpu_int_f !== 1'b1) $display("FAIL rereq_int got %b want 1", cpu_int_f); else pass_cnt++;
        total_cnt++; if (int_vec_f !== 3'd0) $display("FAIL rereq_vec got %0d want 0", int_vec_f); else pass_cnt++;
        int_ack = 1'b1; eoi = 1'b1;
        @(negedge clk);
        int_ack = 1'b0; eoi = 1'b0;
        reg_read(2'd3, df, dr);
        total_cnt++; if (df !== 16'h0002) $display("FAIL ack_eoi_same got %h want 0002", df); else pass_cnt++;
        $display("handshake: re-request vec=%0d", int_vec_f);
        pulse_eoi();
    endtask

    task automatic test_reset_mid_service();
        logic [DATA_W-1:0] df, dr;
        do_reset();
        reg_write(2'd0, 16'h0003);
        reg_write(2'd1, 16'h0003);
        irq_in = 8'h03; @(negedge clk); irq_in = '0;
        wait_int_f(10);
        pulse_ack();
        reg_read(2'd2, df, dr);
        total_cnt++; if (df !== 16'h0002) $display("FAIL pre_rst_pending got %h want 0002", df); else pass_cnt++;
        reg_read(2'd3, df, dr);
        total_cnt++; if (df !== 16'h0002) $display("FAIL pre_rst_status got %h want 0002", df); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (cpu_int_f !== 1'b0) $display("FAIL rst_async_int got %b want 0", cpu_int_f); else pass_cnt++;
        reg_read(2'd2, df, dr);
        total_cnt++; if (df !== 16'h0000) $display("FAIL rst_async_pending got %h want 0000", df); else pass_cnt++;
        reg_read(2'd0, df, dr);
        total_cnt++; if (df !== 16'h0000) $display("FAIL rst_async_enable got %h want 0000", df); else pass_cnt++;
        reg_read(2'd3, df, dr);
        total_cnt++; if (df !== 16'h0000) $display("FAIL rst_async_status got %h want 0000", df); else pass_cnt++;
        $display("reset_mid_service: state cleared");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random_arbitration();
        logic [N_SRC-1:0] lvl, en;
        logic [VEC_W-1:0] exp_f, exp_r;
        int ptr;
        do_reset();
        ptr = 0;
        for (int rnd = 0; rnd < 16; rnd++) begin
            lvl = N_SRC'($urandom_range(1, 255));
            en  = N_SRC'($urandom_range(0, 255));
            if ((lvl & en) == '0) en = lvl;
            irq_in = lvl;
            repeat (4) @(negedge clk);
            reg_write(2'd0, DATA_W'(en));
            wait_int_f(10);
            exp_f = VEC_W'(model_winner(lvl & en, 0));
            exp_r = VEC_W'(model_winner(lvl & en, ptr));
            total_cnt++; if (cpu_int_f !== 1'b1) $display("FAIL rand%0d_int_f got %b want 1", rnd, cpu_int_f); else pass_cnt++;
            total_cnt++; if (cpu_int_r !== 1'b1) $display("FAIL rand%0d_int_r got %b want 1", rnd, cpu_int_r); else pass_cnt++;
            total_cnt++; if (int_vec_f !== exp_f) $display("FAIL rand%0d_vec_f got %0d want %0d", rnd, int_vec_f, exp_f); else pass_cnt++;
            total_cnt++; if (int_vec_r !== exp_r) $display("FAIL rand%0d_vec_r got %0d want %0d", rnd, int_vec_r, exp_r); else pass_cnt++;
            $display("random: round %0d req=%h fixed=%0d rotate=%0d", rnd, lvl & en, int_vec_f, int_vec_r);
            pulse_ack();
            reg_write(2'd0, 16'h0000);
            pulse_eoi();
            ptr = (int'(exp_r) + 1) % N_SRC;
        end
        irq_in = '0;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_fixed_priority();
        test_rotating();
        test_mask_swclear();
        test_handshake();
        test_reset_mid_service();
        test_random_arbitration();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
